pwm_ramp_sequencer: RTL
=======================

PWM_RAMP_SEQUENCER -- requirements
Module: pwm_ramp_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 19: prescaler terminal count; one tick every PRESCALE+1 clocks.
REQ-002 SHALL have parameter WIDTH, default 8: width of the duty, period counter, step and max values.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-high, despite the name.
REQ-005 SHALL have port cfg_valid, input, 1: a configuration word is offered.
REQ-006 SHALL have port cfg_ready, output, 1: configuration can be accepted; high only in IDLE.
REQ-007 SHALL have port cfg_step, input, WIDTH: duty increment or decrement applied per PWM period.
REQ-008 SHALL have port cfg_max, input, WIDTH: ramp ceiling.
REQ-009 SHALL have port cfg_hold, input, 16: number of PWM periods spent in each hold state.
REQ-010 SHALL have port start, input, 1: level-sampled request to begin a ramp.
REQ-011 SHALL have port stop, input, 1: level-sampled abort request.
REQ-012 SHALL have port pwm_out, output, 1: registered PWM waveform.
REQ-013 SHALL have port duty, output, WIDTH: duty value currently applied.
REQ-014 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-015 SHALL have port done, output, 1: one-clock pulse when a sequence completes or is aborted.

Function
REQ-016 SHALL pulse tick when the prescaler equals 0; the prescaler wraps from PRESCALE to 0.
REQ-017 SHALL increment the WIDTH-bit period counter on tick; the counter wraps from 2^WIDTH-1 to 0.
REQ-018 SHALL assert period_end on the tick where the period counter equals 2^WIDTH-1.
REQ-019 SHALL register pwm_out as (period counter < duty), giving one clock of latency; duty 0 -> constant low; duty 255 -> 255/256 high.
REQ-020 SHALL change duty only on period_end, so no PWM period contains a glitch.
REQ-021 SHALL accept configuration when cfg_valid && cfg_ready, latching step, max and hold in that cycle.
REQ-022 SHALL implement states IDLE, UP, HOLD_HI, DOWN and HOLD_LO.
REQ-023 SHALL move IDLE -> UP on start when the latched step != 0; start SHALL be ignored when step == 0.
REQ-024 SHALL, in UP at each period_end, set duty = min(duty+step, max), computed in WIDTH+1 bits; when the result equals max it SHALL go to HOLD_HI.
REQ-025 SHALL, in HOLD_HI, count hold period_ends and then go to DOWN; hold == 0 SHALL leave after one period_end.
REQ-026 SHALL, in DOWN at each period_end, set duty = max(duty-step, 0) with no underflow; at 0 it SHALL go to HOLD_LO.
REQ-027 SHALL, in HOLD_LO, count hold period_ends as in HOLD_HI, then exit as set by REQ-033.
REQ-028 SHALL, on stop in any non-IDLE state, go to IDLE at the next period_end with duty set to 0 and done pulsed.
REQ-029 SHALL give stop priority over start when both are asserted together.
REQ-030 SHALL, when cfg_max == 0, make UP reach HOLD_HI at its first period_end with duty 0.

Reset
REQ-031 SHALL, on reset, set state IDLE, all counters 0, duty 0, pwm_out 0, busy 0 and done 0.
REQ-032 SHALL, on reset, set the latched configuration to step 1, max 2^WIDTH-1 and hold 0; reset mid-ramp SHALL abort immediately with no done pulse.

Configuration
REQ-033 SHALL, with PWM_SEQ_LOOP_EN defined, exit HOLD_LO to UP and repeat until stop; without it, exit HOLD_LO to IDLE and pulse done.

Structure
REQ-034 SHALL place the state enumeration, the default step/max/hold constants and the hold counter width in the shared package pwm_pkg.
REQ-035 SHALL place the prescaler, period counter and comparator in sub-module pwm_core (inputs duty; outputs pwm_out and period_end); the sequencer FSM stays in the top module.

Verification
All scenarios use PRESCALE=0, so one period = 256 clocks.
REQ-036 SHALL check: reset, then configure step=64, max=255, hold=1, start -> duty 64,128,192,255 on successive period_ends, then HOLD_HI for one period, then 191,127,63,0.
REQ-037 SHALL check: duty=128 held -> pwm_out high exactly 128 of 256 clocks, with a rising edge one clock after counter 0.
REQ-038 SHALL check: stop asserted mid-UP at duty 128 -> duty 0 at the next period_end, done pulses, busy drops, cfg_ready rises.
REQ-039 SHALL check: cfg_valid during UP -> no handshake and the latched config is unchanged; cfg_step=0 then start -> busy stays 0.
REQ-040 SHALL check: start and stop asserted together in IDLE -> state stays IDLE; reset asserted mid-DOWN -> all outputs 0 asynchronously, with no done pulse.
REQ-041 SHALL check: with PWM_SEQ_LOOP_EN, a second UP ramp follows HOLD_LO; without it, done pulses and the state is IDLE.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and reset defaults for the PWM ramp sequencer.
package pwm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_HOLD_HI,
        S_DOWN,
        S_HOLD_LO
    } seq_state_t;

    localparam int HOLD_W   = 16;
    localparam int DEF_STEP = 1;
    localparam int DEF_HOLD = 0;
    // All ones; the sequencer keeps the low WIDTH bits as its default ceiling.
    localparam logic [63:0] DEF_MAX = '1;

endpackage

// File: rtl/pwm_core.sv
// Prescaler, free-running period counter and registered duty comparator.
module pwm_core #(
    parameter int PRESCALE = 19,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm_out,
    output logic             period_end
);

    localparam int PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    logic [PS_W-1:0]  presc;
    logic [WIDTH-1:0] period_cnt;
    logic             tick;

    assign tick       = (presc == '0);
    assign period_end = tick && (period_cnt == '1);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            presc      <= '0;
            period_cnt <= '0;
            pwm_out    <= 1'b0;
        end else begin
            if (presc == PS_W'(PRESCALE))
                presc <= '0;
            else
                presc <= presc + PS_W'(1);
            if (tick)
                period_cnt <= period_cnt + WIDTH'(1);
            pwm_out <= (period_cnt < duty);
        end
    end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// PWM duty ramp sequencer: up, hold, down, hold, then idle (or repeat when
// PWM_SEQ_LOOP_EN is defined). rst_n is an active-high asynchronous reset.
//
// state      | meaning
// -----------+--------------------------------------------------
// S_IDLE     | duty 0, configuration accepted, waiting for start
// S_UP       | duty rises by step each period up to max
// S_HOLD_HI  | duty held at max for hold periods
// S_DOWN     | duty falls by step each period down to 0
// S_HOLD_LO  | duty held at 0 for hold periods
module pwm_ramp_sequencer
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 19,
    parameter int WIDTH    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_step,
    input  logic [WIDTH-1:0]  cfg_max,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic              start,
    input  logic              stop,
    output logic              pwm_out,
    output logic [WIDTH-1:0]  duty,
    output logic              busy,
    output logic              done
);

    seq_state_t        state;
    logic [WIDTH-1:0]  step_q;
    logic [WIDTH-1:0]  max_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              stop_req;
    logic              period_end;
    logic [WIDTH:0]    up_sum;
    logic              hold_done;

    pwm_core #(
        .PRESCALE (PRESCALE),
        .WIDTH    (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .duty       (duty),
        .pwm_out    (pwm_out),
        .period_end (period_end)
    );

    assign busy      = (state != S_IDLE);
    assign cfg_ready = (state == S_IDLE);
    // One extra bit so a step past the top of the range saturates at max.
    assign up_sum    = {1'b0, duty} + {1'b0, step_q};
    assign hold_done = (hold_q == '0) || (hold_cnt == hold_q - HOLD_W'(1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= S_IDLE;
            duty     <= '0;
            hold_cnt <= '0;
            step_q   <= WIDTH'(DEF_STEP);
            max_q    <= DEF_MAX[WIDTH-1:0];
            hold_q   <= HOLD_W'(DEF_HOLD);
            stop_req <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cfg_valid && cfg_ready) begin
                step_q <= cfg_step;
                max_q  <= cfg_max;
                hold_q <= cfg_hold;
            end
            // A stop seen mid-period is remembered until the period boundary.
            if (state != S_IDLE && stop)
                stop_req <= 1'b1;

            if (state == S_IDLE) begin
                if (start && !stop && step_q != '0)
                    state <= S_UP;
            end else if (period_end) begin
                if (stop || stop_req) begin
                    state    <= S_IDLE;
                    duty     <= '0;
                    hold_cnt <= '0;
                    stop_req <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    case (state)
                        S_UP: begin
                            if (up_sum >= {1'b0, max_q}) begin
                                duty     <= max_q;
                                hold_cnt <= '0;
                                state    <= S_HOLD_HI;
                            end else begin
                                duty <= up_sum[WIDTH-1:0];
                            end
                        end
                        S_HOLD_HI: begin
                            if (hold_done) begin
                                hold_cnt <= '0;
                                state    <= S_DOWN;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                        S_DOWN: begin
                            if (duty <= step_q) begin
                                duty     <= '0;
                                hold_cnt <= '0;
                                state    <= S_HOLD_LO;
                            end else begin
                                duty <= duty - step_q;
                            end
                        end
                        S_HOLD_LO: begin
                            if (hold_done) begin
                                hold_cnt <= '0;
`ifdef PWM_SEQ_LOOP_EN
                                state    <= S_UP;
`else
                                state    <= S_IDLE;
                                done     <= 1'b1;
`endif
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
